// File: rtl/branch_predict_unit.sv
// Branch predictor with a 2-bit saturating-counter history table and execute-stage branch resolution.
// A mispredict raises a registered redirect to the correct PC and flushes the younger stages.
module branch_predict_unit #(
    parameter int         WIDTH        = 32,
    parameter int         BHT_ENTRIES  = 64,
    parameter logic [1:0] CTR_INIT     = 2'b01,
    parameter int         FLUSH_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] f_pc,
    output logic             f_pred_taken,
    input  logic             ex_valid,
    input  logic             ex_branch,
    input  logic [2:0]       ex_func3,
    input  logic [WIDTH-1:0] ex_rs1,
    input  logic [WIDTH-1:0] ex_rs2,
    input  logic [WIDTH-1:0] ex_pc,
    input  logic [WIDTH-1:0] ex_target,
    input  logic             ex_pred_taken,
    output logic             redirect,
    output logic [WIDTH-1:0] redirect_pc,
    output logic             flush,
    output logic [31:0]      br_count,
    output logic [31:0]      mis_count
);

    localparam int IDX = $clog2(BHT_ENTRIES);
    localparam int CW  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_FLUSH = CW'(FLUSH_CYCLES - 1);

    typedef enum logic {
        IDLE,
        FLUSH
    } state_t;

    logic [1:0]     bht [BHT_ENTRIES];
    state_t         state;
    logic [CW-1:0]  flush_cnt;
    logic [IDX-1:0] f_idx;
    logic [IDX-1:0] ex_idx;
    logic [1:0]     ex_ctr;
    logic           actual;
    logic           legal;
    logic           resolve;
    logic           mispredict;
    logic           unused_f_pc;

    assign f_idx        = f_pc[IDX+1:2];
    assign ex_idx       = ex_pc[IDX+1:2];
    assign f_pred_taken = bht[f_idx][1];
    assign ex_ctr       = bht[ex_idx];
    assign unused_f_pc  = ^{f_pc[WIDTH-1:IDX+2], f_pc[1:0]};

    always_comb begin
        actual = 1'b0;
        legal  = 1'b1;
        case (ex_func3)
            3'b000:  actual = (ex_rs1 == ex_rs2);
            3'b001:  actual = (ex_rs1 != ex_rs2);
            3'b100:  actual = ($signed(ex_rs1) <  $signed(ex_rs2));
            3'b101:  actual = ($signed(ex_rs1) >= $signed(ex_rs2));
            3'b110:  actual = (ex_rs1 <  ex_rs2);
            3'b111:  actual = (ex_rs1 >= ex_rs2);
            default: legal  = 1'b0;
        endcase
    end

    // Wrong-path instructions arrive while flushing, so only IDLE may resolve.
    assign resolve    = ex_valid & ex_branch & legal & (state == IDLE);
    assign mispredict = resolve & (actual != ex_pred_taken);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht[i] <= CTR_INIT;
            end
        end else if (resolve) begin
            if (actual && ex_ctr != 2'b11) begin
                bht[ex_idx] <= ex_ctr + 2'b01;
            end else if (!actual && ex_ctr != 2'b00) begin
                bht[ex_idx] <= ex_ctr - 2'b01;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            br_count  <= '0;
            mis_count <= '0;
        end else begin
            if (resolve && br_count != 32'hFFFF_FFFF) begin
                br_count <= br_count + 32'd1;
            end
            if (mispredict && mis_count != 32'hFFFF_FFFF) begin
                mis_count <= mis_count + 32'd1;
            end
        end
    end

    // redirect is asserted on entry to FLUSH only, so it lasts exactly one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            flush_cnt   <= '0;
            redirect    <= 1'b0;
            flush       <= 1'b0;
            redirect_pc <= '0;
        end else begin
            redirect <= 1'b0;
            case (state)
                IDLE: begin
                    if (mispredict) begin
                        state       <= FLUSH;
                        flush       <= 1'b1;
                        redirect    <= 1'b1;
                        flush_cnt   <= '0;
                        redirect_pc <= actual ? ex_target : ex_pc + WIDTH'(4);
                    end
                end
                FLUSH: begin
                    if (flush_cnt == LAST_FLUSH) begin
                        state <= IDLE;
                        flush <= 1'b0;
                    end else begin
                        flush_cnt <= flush_cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: directed scenarios plus randomized traffic
// compared against a behavioural predictor model kept in the bench.
module tb_branch_predict_unit;

    localparam int         WIDTH = 32;
    localparam int         BHT   = 64;
    localparam int         FC    = 2;
    localparam logic [1:0] CINIT = 2'b01;

    logic              clk = 1'b0;
    logic              reset;
    logic [WIDTH-1:0]  f_pc;
    logic              f_pred_taken;
    logic              ex_valid;
    logic              ex_branch;
    logic [2:0]        ex_func3;
    logic [WIDTH-1:0]  ex_rs1;
    logic [WIDTH-1:0]  ex_rs2;
    logic [WIDTH-1:0]  ex_pc;
    logic [WIDTH-1:0]  ex_target;
    logic              ex_pred_taken;
    logic              redirect;
    logic [WIDTH-1:0]  redirect_pc;
    logic              flush;
    logic [31:0]       br_count;
    logic [31:0]       mis_count;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state: counter values as plain integers, flush as a countdown.
    int          m_ctr [BHT];
    int          m_flush_left;
    logic        m_redirect;
    logic        m_flush;
    logic [31:0] m_rpc;
    logic [31:0] m_br;
    logic [31:0] m_mis;

    branch_predict_unit #(
        .WIDTH(WIDTH), .BHT_ENTRIES(BHT), .CTR_INIT(CINIT), .FLUSH_CYCLES(FC)
    ) dut (
        .clk(clk), .reset(reset), .f_pc(f_pc), .f_pred_taken(f_pred_taken),
        .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_func3(ex_func3),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_pc(ex_pc), .ex_target(ex_target),
        .ex_pred_taken(ex_pred_taken), .redirect(redirect), .redirect_pc(redirect_pc),
        .flush(flush), .br_count(br_count), .mis_count(mis_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "[TB] timeout");
    end

    function automatic logic outcome(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return int'(a) < int'(b);
            3'd5:    return !(int'(a) < int'(b));
            3'd6:    return a < b;
            3'd7:    return !(a < b);
            default: return 1'b0;
        endcase
    endfunction

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc / 4) % BHT);
    endfunction

    function automatic logic model_pred(input logic [31:0] pc);
        return m_ctr[idx_of(pc)] >= 2;
    endfunction

    // Advance the model by one clock using the currently driven inputs, then step the DUT.
    task automatic cycle();
        logic act, res, mis;
        int   i;
        if (reset) begin
            foreach (m_ctr[k]) m_ctr[k] = int'(CINIT);
            m_flush_left = 0;
            m_redirect   = 1'b0;
            m_rpc        = '0;
            m_br         = '0;
            m_mis        = '0;
        end else begin
            act = outcome(ex_func3, ex_rs1, ex_rs2);
            res = ex_valid && ex_branch && ex_func3 != 3'd2 && ex_func3 != 3'd3 && m_flush_left == 0;
            mis = res && (act != ex_pred_taken);
            m_redirect = 1'b0;
            if (m_flush_left > 0) m_flush_left--;
            if (res) begin
                i = idx_of(ex_pc);
                if (act) m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                else     m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
                if (m_br != 32'hFFFF_FFFF) m_br++;
            end
            if (mis) begin
                if (m_mis != 32'hFFFF_FFFF) m_mis++;
                m_flush_left = FC;
                m_redirect   = 1'b1;
                m_rpc        = act ? ex_target : ex_pc + 32'd4;
            end
        end
        m_flush = m_flush_left > 0;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic b, input logic [2:0] f3,
                                 input logic [31:0] rs1, input logic [31:0] rs2,
                                 input logic [31:0] pc, input logic [31:0] tgt, input logic pt);
        ex_valid      = v;
        ex_branch     = b;
        ex_func3      = f3;
        ex_rs1        = rs1;
        ex_rs2        = rs2;
        ex_pc         = pc;
        ex_target     = tgt;
        ex_pred_taken = pt;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        applyStimulus(0, 0, 3'd0, 0, 0, 0, 0, 0);
        cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        applyStimulus(0, 0, 3'd0, 0, 0, 0, 0, 0);
        f_pc = 32'h40;
        cycle();
        cycle();
        vectors++; if (redirect !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_redirect: got %b expected 0", redirect); end
        vectors++; if (flush !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_flush: got %b expected 0", flush); end
        vectors++; if (redirect_pc !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_redirect_pc: got %h expected 0", redirect_pc); end
        vectors++; if (br_count !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_br_count: got %0d expected 0", br_count); end
        vectors++; if (mis_count !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_mis_count: got %0d expected 0", mis_count); end
        for (int k = 0; k < 4; k++) begin
            f_pc = 32'h1000 + 32'(k * 20);
            #1;
            vectors++; if (f_pred_taken !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_pred pc=%h: got %b expected 0", f_pc, f_pred_taken); end
        end
        reset = 1'b0;
    endtask

    task automatic test_beq_mispredict();
        do_reset();
        f_pc = 32'h40;
        applyStimulus(1, 1, 3'd0, 5, 5, 32'h40, 32'h100, 0);
        #1;
        vectors++; if (f_pred_taken !== 1'b0) begin miscompares++; $display("[TB] FAIL beq_pred_before: got %b expected 0", f_pred_taken); end
        cycle();
        applyStimulus(0, 0, 3'd0, 0, 0, 0, 0, 0);
        vectors++; if (redirect !== 1'b1) begin miscompares++; $display("[TB] FAIL beq_redirect: got %b expected 1", redirect); end
        vectors++; if (redirect_pc !== 32'h100) begin miscompares++; $display("[TB] FAIL beq_redirect_pc: got %h expected 100", redirect_pc); end
        vectors++; if (flush !== 1'b1) begin miscompares++; $display("[TB] FAIL beq_flush1: got %b expected 1", flush); end
        vectors++; if (mis_count !== 32'd1) begin miscompares++; $display("[TB] FAIL beq_mis_count: got %0d expected 1", mis_count); end
        vectors++; if (br_count !== 32'd1) begin miscompares++; $display("[TB] FAIL beq_br_count: got %0d expected 1", br_count); end
        vectors++; if (f_pred_taken !== 1'b1) begin miscompares++; $display("[TB] FAIL beq_pred_after: got %b expected 1", f_pred_taken); end
        cycle();
        vectors++; if (flush !== 1'b1) begin miscompares++; $display("[TB] FAIL beq_flush2: got %b expected 1", flush); end
        vectors++; if (redirect !== 1'b0) begin miscompares++; $display("[TB] FAIL beq_redirect_once: got %b expected 0", redirect); end
        cycle();
        vectors++; if (flush !== 1'b0) begin miscompares++; $display("[TB] FAIL beq_flush_end: got %b expected 0", flush); end
        vectors++; if (redirect_pc !== 32'h100) begin miscompares++; $display("[TB] FAIL beq_pc_hold: got %h expected 100", redirect_pc); end
    endtask

    task automatic test_compare();
        do_reset();
        applyStimulus(1, 1, 3'd4, 32'hFFFF_FFFF, 32'd1, 32'h80, 32'h200, 1);
        cycle();
        vectors++; if (redirect !== 1'b0 || flush !== 1'b0) begin miscompares++; $display("[TB] FAIL blt_no_redirect: got %b/%b expected 0/0", redirect, flush); end
        applyStimulus(1, 1, 3'd6, 32'hFFFF_FFFF, 32'd1, 32'h84, 32'h200, 0);
        cycle();
        applyStimulus(0, 0, 3'd0, 0, 0, 0, 0, 0);
        vectors++; if (redirect !== 1'b0 || flush !== 1'b0) begin miscompares++; $display("[TB] FAIL bltu_no_redirect: got %b/%b expected 0/0", redirect, flush); end
        vectors++; if (br_count !== 32'd2) begin miscompares++; $display("[TB] FAIL cmp_br_count: got %0d expected 2", br_count); end
        vectors++; if (mis_count !== 32'd0) begin miscompares++; $display("[TB] FAIL cmp_mis_count: got %0d expected 0", mis_count); end
        f_pc = 32'h80; #1;
        vectors++; if (f_pred_taken !== 1'b1) begin miscompares++; $display("[TB] FAIL blt_counter: got %b expected 1", f_pred_taken); end
        f_pc = 32'h84; #1;
        vectors++; if (f_pred_taken !== 1'b0) begin miscompares++; $display("[TB] FAIL bltu_counter: got %b expected 0", f_pred_taken); end
    endtask

    task automatic test_saturation();
        bit pre_t [4]  = '{0, 1, 1, 1};
        bit post_t [4] = '{1, 1, 1, 1};
        bit pre_n [4]  = '{1, 1, 0, 0};
        bit post_n [4] = '{1, 0, 0, 0};
        do_reset();
        f_pc = 32'h40;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1, 1, 3'd0, 7, 7, 32'h40, 32'h500, 1);
            #1;
            vectors++; if (f_pred_taken !== pre_t[k]) begin miscompares++; $display("[TB] FAIL sat_taken_old%0d: got %b expected %b", k, f_pred_taken, pre_t[k]); end
            cycle();
            vectors++; if (f_pred_taken !== post_t[k]) begin miscompares++; $display("[TB] FAIL sat_taken_new%0d: got %b expected %b", k, f_pred_taken, post_t[k]); end
        end
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1, 1, 3'd0, 7, 8, 32'h40, 32'h500, 0);
            #1;
            vectors++; if (f_pred_taken !== pre_n[k]) begin miscompares++; $display("[TB] FAIL sat_nt_old%0d: got %b expected %b", k, f_pred_taken, pre_n[k]); end
            cycle();
            vectors++; if (f_pred_taken !== post_n[k]) begin miscompares++; $display("[TB] FAIL sat_nt_new%0d: got %b expected %b", k, f_pred_taken, post_n[k]); end
        end
        applyStimulus(0, 0, 3'd0, 0, 0, 0, 0, 0);
        vectors++; if (br_count !== 32'd8 || mis_count !== 32'd0) begin miscompares++; $display("[TB] FAIL sat_counts: got %0d/%0d expected 8/0", br_count, mis_count); end
        vectors++; if (flush !== 1'b0) begin miscompares++; $display("[TB] FAIL sat_no_flush: got %b expected 0", flush); end
    endtask

    task automatic test_flush_ignore();
        do_reset();
        applyStimulus(1, 1, 3'd0, 5, 5, 32'h40, 32'h100, 0);
        cycle();
        applyStimulus(1, 1, 3'd1, 1, 2, 32'hC0, 32'h300, 0);
        cycle();
        vectors++; if (redirect !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_no_redirect1: got %b expected 0", redirect); end
        vectors++; if (flush !== 1'b1) begin miscompares++; $display("[TB] FAIL flush_second: got %b expected 1", flush); end
        cycle();
        applyStimulus(0, 0, 3'd0, 0, 0, 0, 0, 0);
        vectors++; if (redirect !== 1'b0 || flush !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_end: got %b/%b expected 0/0", redirect, flush); end
        vectors++; if (mis_count !== 32'd1 || br_count !== 32'd1) begin miscompares++; $display("[TB] FAIL flush_counts: got %0d/%0d expected 1/1", mis_count, br_count); end
        vectors++; if (redirect_pc !== 32'h100) begin miscompares++; $display("[TB] FAIL flush_pc: got %h expected 100", redirect_pc); end
        f_pc = 32'hC0; #1;
        vectors++; if (f_pred_taken !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_counter: got %b expected 0", f_pred_taken); end
    endtask

    task automatic test_reset_in_flush();
        do_reset();
        f_pc = 32'h40;
        applyStimulus(1, 1, 3'd0, 5, 5, 32'h40, 32'h100, 0);
        cycle();
        vectors++; if (flush !== 1'b1) begin miscompares++; $display("[TB] FAIL rif_pre_flush: got %b expected 1", flush); end
        reset = 1'b1;
        cycle();
        vectors++; if (flush !== 1'b0 || redirect !== 1'b0) begin miscompares++; $display("[TB] FAIL rif_outputs: got %b/%b expected 0/0", flush, redirect); end
        vectors++; if (br_count !== 32'd0 || mis_count !== 32'd0) begin miscompares++; $display("[TB] FAIL rif_counts: got %0d/%0d expected 0/0", br_count, mis_count); end
        vectors++; if (f_pred_taken !== 1'b0) begin miscompares++; $display("[TB] FAIL rif_counter: got %b expected 0", f_pred_taken); end
        reset = 1'b0;
        applyStimulus(0, 0, 3'd0, 0, 0, 0, 0, 0);
        cycle();
        vectors++; if (flush !== 1'b0 || redirect !== 1'b0) begin miscompares++; $display("[TB] FAIL rif_after: got %b/%b expected 0/0", flush, redirect); end
    endtask

    task automatic test_nonbranch();
        do_reset();
        f_pc = 32'h40;
        applyStimulus(1, 1, 3'd2, 5, 5, 32'h40, 32'h100, 1);
        cycle();
        applyStimulus(1, 1, 3'd3, 5, 5, 32'h40, 32'h100, 0);
        cycle();
        applyStimulus(0, 0, 3'd0, 0, 0, 0, 0, 0);
        vectors++; if (redirect !== 1'b0 || flush !== 1'b0) begin miscompares++; $display("[TB] FAIL nb_redirect: got %b/%b expected 0/0", redirect, flush); end
        vectors++; if (br_count !== 32'd0 || mis_count !== 32'd0) begin miscompares++; $display("[TB] FAIL nb_counts: got %0d/%0d expected 0/0", br_count, mis_count); end
        vectors++; if (f_pred_taken !== 1'b0) begin miscompares++; $display("[TB] FAIL nb_counter: got %b expected 0", f_pred_taken); end
        cycle();
        vectors++; if (redirect_pc !== 32'h0) begin miscompares++; $display("[TB] FAIL nb_redirect_pc: got %h expected 0", redirect_pc); end
    endtask

    task automatic test_random();
        logic [31:0] pc, fpc, a, b, tgt, hi;
        logic [2:0]  f3;
        logic        pt;
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 39) == 0);
            hi  = $urandom;
            pc  = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : ((hi & 32'hFFFF_FF00) | (32'($urandom_range(0, 7)) << 2));
            hi  = $urandom;
            fpc = (hi & 32'hFFFF_FF00) | (32'($urandom_range(0, 7)) << 2);
            a   = $urandom;
            b   = ($urandom_range(0, 2) == 0) ? a : $urandom;
            tgt = $urandom;
            f3  = 3'($urandom_range(0, 7));
            pt  = ($urandom_range(0, 1) == 0) ? model_pred(pc) : 1'($urandom_range(0, 1));
            applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0), f3, a, b, pc, tgt, pt);
            f_pc = fpc;
            #1;
            vectors++; if (f_pred_taken !== model_pred(fpc)) begin miscompares++; $display("[TB] FAIL rnd_pred n=%0d: got %b expected %b", n, f_pred_taken, model_pred(fpc)); end
            cycle();
            vectors++; if (redirect !== m_redirect) begin miscompares++; $display("[TB] FAIL rnd_redirect n=%0d: got %b expected %b", n, redirect, m_redirect); end
            vectors++; if (flush !== m_flush) begin miscompares++; $display("[TB] FAIL rnd_flush n=%0d: got %b expected %b", n, flush, m_flush); end
            vectors++; if (redirect_pc !== m_rpc) begin miscompares++; $display("[TB] FAIL rnd_redirect_pc n=%0d: got %h expected %h", n, redirect_pc, m_rpc); end
            vectors++; if (br_count !== m_br) begin miscompares++; $display("[TB] FAIL rnd_br_count n=%0d: got %0d expected %0d", n, br_count, m_br); end
            vectors++; if (mis_count !== m_mis) begin miscompares++; $display("[TB] FAIL rnd_mis_count n=%0d: got %0d expected %0d", n, mis_count, m_mis); end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        f_pc  = '0;
        applyStimulus(0, 0, 3'd0, 0, 0, 0, 0, 0);
        m_flush_left = 0;
        m_flush      = 1'b0;
        m_redirect   = 1'b0;
        m_rpc        = '0;
        m_br         = '0;
        m_mis        = '0;
        foreach (m_ctr[k]) m_ctr[k] = int'(CINIT);
        test_reset();
        test_beq_mispredict();
        test_compare();
        test_saturation();
        test_flush_ignore();
        test_reset_in_flush();
        test_nonbranch();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 Parameter WIDTH, default 32: data and PC width in bits.
REQ-002 Parameter BHT_ENTRIES, default 64: branch history table depth; power of 2, at least 2; IDX = log2(BHT_ENTRIES).
REQ-003 Parameter CTR_INIT, default 2'b01: reset value of every 2-bit counter (weakly not-taken).
REQ-004 Parameter FLUSH_CYCLES, default 2: flush pulse length; at least 1.
REQ-005 Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- f_pc  in  WIDTH  fetch-stage PC.
- f_pred_taken  out  1  combinational prediction for f_pc.
- ex_valid  in  1  execute-stage instruction valid.
- ex_branch  in  1  execute instruction is a conditional branch.
- ex_func3  in  3  branch condition code.
- ex_rs1, ex_rs2  in  WIDTH  compare operands.
- ex_pc  in  WIDTH  PC of the execute instruction.
- ex_target  in  WIDTH  computed taken target.
- ex_pred_taken  in  1  prediction carried down the pipe with the instruction.
- redirect  out  1  registered one-cycle pulse: fetch loads redirect_pc.
- redirect_pc  out  WIDTH  registered correct next PC.
- flush  out  1  registered: kill the younger pipeline stages.
- br_count  out  32  resolved-branch counter.
- mis_count  out  32  mispredict counter.

Function
REQ-006 Table index = PC[IDX+1:2], for both fetch lookup and execute update.
REQ-007 f_pred_taken = MSB of the counter indexed by f_pc, read combinationally, with no bypass of a same-cycle update.
REQ-008 Actual outcome by ex_func3:
- 000 eq
- 001 ne
- 100 signed lt
- 101 signed ge
- 110 unsigned lt
- 111 unsigned ge
- All comparisons are full WIDTH.
REQ-009 ex_func3 010/011 is a non-branch: no resolve, no table update, no count, no redirect.
REQ-010 Resolve event = ex_valid & ex_branch & legal func3 & state==IDLE.
REQ-011 Execute inputs are ignored while in FLUSH, because they are wrong-path.
REQ-012 On a resolve event, the indexed counter updates at the next edge.
- Taken: increment, saturating at 3.
- Not taken: decrement, saturating at 0.
REQ-013 On a resolve event, br_count increments by 1, saturating at 32'hFFFF_FFFF.
REQ-014 Mispredict = resolve event & (actual != ex_pred_taken). On a mispredict, mis_count increments by 1, saturating at 32'hFFFF_FFFF.
REQ-015 FSM states: IDLE, FLUSH.
- IDLE -> FLUSH on a mispredict.
- FLUSH lasts exactly FLUSH_CYCLES cycles, then returns to IDLE.
- No other transitions.
REQ-016 flush = 1 in every FLUSH cycle and 0 in IDLE.
REQ-017 redirect = 1 only in the first FLUSH cycle.
REQ-018 redirect_pc is registered on a mispredict: ex_target if actual taken, else ex_pc + 4, modulo 2^WIDTH.
- redirect_pc holds its value otherwise.
REQ-019 Latency: a mispredict in cycle N produces redirect and flush in cycle N+1; the table update is visible to f_pred_taken in cycle N+1.
REQ-020 A correct prediction produces no redirect and no flush.
REQ-021 A fetch lookup and an update to the same index in the same cycle: the lookup returns the old value.

Reset
REQ-022 While reset = 1 at an edge:
- All counters load CTR_INIT.
- state = IDLE.
- redirect = 0, flush = 0, redirect_pc = 0, br_count = 0, mis_count = 0.
REQ-023 Reset overrides all other events in the same cycle, including a mid-FLUSH state or a simultaneous mispredict; no redirect follows reset.
REQ-024 f_pred_taken after reset = CTR_INIT[1] (0 at default).

Verification
REQ-025 Scenario: beq, rs1 = rs2 = 5, ex_pred_taken = 0, ex_target = 0x100, ex_pc = 0x40.
- Next cycle: redirect = 1, redirect_pc = 0x100, flush = 1 for 2 cycles, mis_count = 1, br_count = 1.
REQ-026 Scenario: blt rs1 = 0xFFFF_FFFF, rs2 = 1 -> taken; bltu with the same operands -> not taken.
- Both resolved with matching ex_pred_taken -> no redirect, br_count = 2.
REQ-027 Scenario: pc 0x40 taken 4 times in a row.
- Counter goes 1 -> 2 -> 3 -> 3 (saturates).
- f_pred_taken(0x40) = 1 from the cycle after the first update.
- Then 3 not-taken resolves -> counter 0; a fourth keeps it at 0.
REQ-028 Scenario: mispredict, then another valid branch presented during both FLUSH cycles.
- No counter change, no second redirect, mis_count = 1.
REQ-029 Scenario: reset asserted in the first FLUSH cycle.
- Next cycle: flush = 0, redirect = 0, counters = 0, the entry at 0x40 is back to CTR_INIT.
REQ-030 Scenario: func3 = 010 with ex_valid = ex_branch = 1.
- No update, no redirect, counts unchanged.
